// File: rtl/hs_upload_reader.sv
// Serves a fixed-length window of game RAM to a host upload session, halting the
// game CPU while bytes are fetched one host address at a time.
module hs_upload_reader #(
  parameter logic [7:0] INDEX       = 8'd3,
  parameter int         ADDR_W      = 11,
  parameter int         BASE_ADDR   = 0,
  parameter int         LENGTH      = 39,
  parameter int         RAM_LATENCY = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              save_request,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              pause_cpu,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  input  logic [7:0]        data_from_ram,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    PAUSE = 3'd2,
    FETCH = 3'd3,
    READY = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, next_state;
  logic [2:0]  cnt;
  logic [24:0] cur_addr;
  logic        session, in_range, addr_chg, cnt_last, latch_ram, latch_ff;

  // Host strobes carry no information here: the address change alone drives refetches.
  logic unused_rd;
  assign unused_rd = ioctl_rd;

  assign session  = ioctl_upload && (ioctl_index == INDEX);
  assign in_range = ioctl_addr < 25'(LENGTH);
  assign addr_chg = ioctl_addr != cur_addr;
  assign cnt_last = cnt == 3'(RAM_LATENCY - 1);

  // A byte is only committed while the session and the CPU halt are both still valid.
  assign latch_ff  = (state == FETCH) && ioctl_upload && paused && !in_range;
  assign latch_ram = (state == FETCH) && ioctl_upload && paused && in_range &&
                     !addr_chg && cnt_last;

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (session)           next_state = PAUSE;
        else if (save_request) next_state = REQ;
      end
      REQ: begin
        if (session) next_state = PAUSE;
      end
      PAUSE: begin
        if (!ioctl_upload) next_state = DONE;
        else if (paused)   next_state = FETCH;
      end
      FETCH: begin
        if (!ioctl_upload)               next_state = DONE;
        else if (!paused)                next_state = PAUSE;
        else if (latch_ff || latch_ram)  next_state = READY;
      end
      READY: begin
        if (!ioctl_upload) next_state = DONE;
        else if (addr_chg) next_state = FETCH;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ioctl_upload_req = (state == REQ);
    pause_cpu        = (state == PAUSE) || (state == FETCH) || (state == READY);
    ram_read         = (state == FETCH) && in_range && paused;
    ram_address      = '0;
    if (state == FETCH && in_range)
      ram_address = ADDR_W'(BASE_ADDR) + ioctl_addr[ADDR_W-1:0];
    fsm_state        = state;
  end

  // Fetch datapath: cur_addr remembers the address the current fetch was started for.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_din <= 8'h00;
      cnt       <= '0;
      cur_addr  <= '0;
    end else begin
      if (next_state == FETCH) cur_addr <= ioctl_addr;
      if (latch_ff)       ioctl_din <= 8'hFF;
      else if (latch_ram) ioctl_din <= data_from_ram;
      if (state == FETCH && ioctl_upload && paused && in_range && !addr_chg && !cnt_last)
        cnt <= cnt + 3'd1;
      else
        cnt <= '0;
    end
  end

endmodule
